// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI primary: FSM encoding, frame size,
// default divider and the request payload captured on start.
package spi_pkg;

  localparam int unsigned FRAME_BITS      = 16;
  localparam int unsigned CLK_DIV_DEFAULT = 25;
  localparam int unsigned DIV_W           = 8;
  localparam int unsigned BIT_W           = $clog2(FRAME_BITS);
  localparam int unsigned ADDR_W          = 6;
  localparam int unsigned DATA_W          = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } spi_req_t;

  // Command byte then payload; reads shift out all-ones as don't-care data.
  function automatic logic [FRAME_BITS-1:0] build_frame(input spi_req_t req);
    return {req.rw, 1'b0, req.addr, (req.rw ? 8'hFF : req.wdata)};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick for the SPI clock. Held cleared while the FSM is idle so
// every frame starts with a full first phase.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick_c
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;

  assign tick_c = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= DIV_W'(cnt_q + 1'b1);
    end
  end

endmodule

// File: rtl/spi_primary.sv
// SPI mode-3 primary issuing 16-bit register frames (command byte, data byte)
// with registered pin and status outputs.
module spi_primary
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              SPI_CSN,
  output logic              SPI_CLK,
  output logic              SPI_SDI,
  input  logic              SPI_SDO
);

  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] FIRST_DATA = BIT_W'(FRAME_BITS / 2);

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic                    rw_q, rw_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    high_q, high_d;
  logic [DATA_W-1:0]       cap_q, cap_d;
  logic [DATA_W-1:0]       rdata_d;
  logic                    busy_d, done_d, csn_d, sclk_d, sdi_d;
  logic                    accept_c;
  logic                    tick_c;
  spi_req_t                req_c;

  assign req_c = '{rw: rw, addr: addr, wdata: wdata};

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == IDLE),
    .tick_c  (tick_c)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rw_d     = rw_q;
    bit_d    = bit_q;
    high_d   = high_q;
    cap_d    = cap_q;
    rdata_d  = rdata;
    busy_d   = busy;
    done_d   = 1'b0;
    csn_d    = SPI_CSN;
    sclk_d   = SPI_CLK;
    sdi_d    = SPI_SDI;
    accept_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) accept_c = 1'b1;
      end
      SETUP: begin
        if (tick_c) begin
          state_d = XFER;
          sclk_d  = 1'b0;
          sdi_d   = tx_q[FRAME_BITS-1];
          bit_d   = '0;
          high_d  = 1'b0;
        end
      end
      XFER: begin
        if (tick_c) begin
          if (!high_q) begin
            sclk_d = 1'b1;
            high_d = 1'b1;
            if (rw_q && (bit_q >= FIRST_DATA)) cap_d = {cap_q[DATA_W-2:0], SPI_SDO};
          end else if (bit_q == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            bit_d  = BIT_W'(bit_q + 1'b1);
            high_d = 1'b0;
            sclk_d = 1'b0;
            sdi_d  = tx_q[FRAME_BITS-2];
            tx_d   = {tx_q[FRAME_BITS-2:0], 1'b1};
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          state_d = GAP;
          csn_d   = 1'b1;
          sdi_d   = 1'b1;
          done_d  = 1'b1;
          if (rw_q) rdata_d = cap_q;
        end
      end
      GAP: begin
        // A start present as the gap expires is taken at the point IDLE would
        // sample it, so a held start yields gaps of exactly CLK_DIV cycles.
        if (tick_c) begin
          if (start) begin
            accept_c = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_c) begin
      state_d = SETUP;
      rw_d    = req_c.rw;
      tx_d    = build_frame(req_c);
      cap_d   = '0;
      csn_d   = 1'b0;
      busy_d  = 1'b1;
      sclk_d  = 1'b1;
      sdi_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rw_q    <= 1'b0;
      bit_q   <= '0;
      high_q  <= 1'b0;
      cap_q   <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SPI_CSN <= 1'b1;
      SPI_CLK <= 1'b1;
      SPI_SDI <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rw_q    <= rw_d;
      bit_q   <= bit_d;
      high_q  <= high_d;
      cap_q   <= cap_d;
      rdata   <= rdata_d;
      busy    <= busy_d;
      done    <= done_d;
      SPI_CSN <= csn_d;
      SPI_CLK <= sclk_d;
      SPI_SDI <= sdi_d;
    end
  end

endmodule

// File: tb/tb_spi_primary.sv
// Directed bench for spi_primary (CLK_DIV=2) against a mode-3 secondary mimic.
module tb_spi_primary;

  localparam int unsigned DIV = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       rw;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       SPI_CSN;
  logic       SPI_CLK;
  logic       SPI_SDI;
  logic       SPI_SDO;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_primary #(.CLK_DIV(DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .SPI_CSN (SPI_CSN),
    .SPI_CLK (SPI_CLK),
    .SPI_SDI (SPI_SDI),
    .SPI_SDO (SPI_SDO)
  );

  // Secondary mimic: oversamples the pins, shifts SDI on SCLK rise, drives read
  // data on SCLK fall from a two-entry data file, then zeros once exhausted.
  logic        m_prev_csn  = 1'b1;
  logic        m_prev_sclk = 1'b1;
  logic        m_sdo       = 1'b1;
  logic [15:0] m_rx        = '0;
  logic [7:0]  m_byte      = '0;
  logic [7:0]  m_addr      = '0;
  logic [7:0]  m_data      = '0;
  int          m_bits      = 0;
  int          m_falls     = 0;
  int          m_ptr       = 0;
  int          m_frames    = 0;
  int          done_total  = 0;

  assign SPI_SDO = m_sdo;

  function automatic logic [7:0] file_line(input int idx);
    case (idx)
      0:       return 8'hE5;
      1:       return 8'h7F;
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    m_prev_csn  <= SPI_CSN;
    m_prev_sclk <= SPI_CLK;
    if (done === 1'b1) done_total <= done_total + 1;
    if (m_prev_csn && !SPI_CSN) begin
      m_bits  <= 0;
      m_falls <= 0;
      m_byte  <= file_line(m_ptr);
    end else if (!m_prev_csn && SPI_CSN) begin
      m_sdo <= 1'b1;
      if (m_bits == 16) begin
        m_addr   <= m_rx[15:8];
        m_data   <= m_rx[7:0];
        m_frames <= m_frames + 1;
        if (m_rx[15]) m_ptr <= m_ptr + 1;
        $display("[MIMIC] address %08b data %08b", m_rx[15:8], m_rx[7:0]);
      end
    end else if (!SPI_CSN) begin
      if (!m_prev_sclk && SPI_CLK) begin
        m_rx   <= {m_rx[14:0], SPI_SDI};
        m_bits <= m_bits + 1;
      end
      if (m_prev_sclk && !SPI_CLK) begin
        if (m_falls >= 8) m_sdo <= m_byte[3'(15 - m_falls)];
        m_falls <= m_falls + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One start pulse, then sample each cycle k+n at the falling clk edge until
  // busy drops; optional stray start pulse at cycle k+extra_at.
  task automatic run_frame(input logic f_rw, input logic [5:0] f_addr, input logic [7:0] f_wdata,
                           input int extra_at, output int done_n, output int csn_lo,
                           output int busy_lo_n, output logic [7:0] rd, output int done_cnt,
                           output logic csn1, output logic busy1);
    @(negedge clk);
    start = 1'b1; rw = f_rw; addr = f_addr; wdata = f_wdata;
    done_n = 0; csn_lo = 0; busy_lo_n = 0; rd = 8'hxx; done_cnt = 0; csn1 = 1'bx; busy1 = 1'bx;
    for (int n = 1; n <= 200 && busy_lo_n == 0; n++) begin
      @(negedge clk);
      start = (n == extra_at);
      if (n == 1) begin csn1 = SPI_CSN; busy1 = busy; end
      if (!SPI_CSN) csn_lo++;
      if (done) begin done_cnt++; done_n = n; rd = rdata; end
      if (!busy) busy_lo_n = n;
    end
  endtask

  int         done_n, csn_lo, busy_lo_n, done_cnt, after_lo, after_done, dt_before;
  logic [7:0] rd;
  logic       csn1, busy1;
  int         d_at[3];
  int         gaps[4];
  int         n_done, n_gaps, hi_run;
  logic       seen_low;

  initial begin
    reset_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_csn",   32'(SPI_CSN), 32'd1);
    check("rst_sclk",  32'(SPI_CLK), 32'd1);
    check("rst_sdi",   32'(SPI_SDI), 32'd1);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_rdata", 32'(rdata),   32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0x2D <- 0x08
    run_frame(1'b0, 6'h2D, 8'h08, 0, done_n, csn_lo, busy_lo_n, rd, done_cnt, csn1, busy1);
    check("wr_csn_k1",   32'(csn1),      32'd0);
    check("wr_busy_k1",  32'(busy1),     32'd1);
    check("wr_csn_low",  32'(csn_lo),    32'd68);
    check("wr_done_at",  32'(done_n),    32'd69);
    check("wr_busy_lo",  32'(busy_lo_n), 32'd71);
    check("wr_done_cnt", 32'(done_cnt),  32'd1);
    check("wr_rdata",    32'(rd),        32'h00);
    check("wr_m_addr",   32'(m_addr),    32'h2D);
    check("wr_m_data",   32'(m_data),    32'h08);

    // Read 0x00, data file line 0xE5
    run_frame(1'b1, 6'h00, 8'h00, 0, done_n, csn_lo, busy_lo_n, rd, done_cnt, csn1, busy1);
    check("rd_m_addr",   32'(m_addr),    32'h80);
    check("rd_m_data",   32'(m_data),    32'hFF);
    check("rd_rdata",    32'(rd),        32'hE5);
    check("rd_done_at",  32'(done_n),    32'd69);
    check("rd_csn_low",  32'(csn_lo),    32'd68);

    // Stray start 10 cycles into a write frame
    run_frame(1'b0, 6'h11, 8'hA5, 10, done_n, csn_lo, busy_lo_n, rd, done_cnt, csn1, busy1);
    check("dup_done_cnt", 32'(done_cnt), 32'd1);
    check("dup_csn_low",  32'(csn_lo),   32'd68);
    check("dup_rdata",    32'(rd),       32'hE5);
    after_lo = 0; after_done = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (!SPI_CSN) after_lo++;
      if (done) after_done++;
    end
    check("dup_no_frame", 32'(after_lo),   32'd0);
    check("dup_no_done",  32'(after_done), 32'd0);
    check("dup_m_data",   32'(m_data),     32'hA5);

    // Reset during bit 5 of a write to 0x3A (bit 5 on SDI is 0)
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 6'h3A; wdata = 8'h99;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    check("rst5_sclk_low", 32'(SPI_CLK), 32'd0);
    check("rst5_sdi",      32'(SPI_SDI), 32'd0);
    dt_before = done_total;
    #1 reset_n = 1'b0;
    #1;
    check("rst5_csn",  32'(SPI_CSN), 32'd1);
    check("rst5_sclk", 32'(SPI_CLK), 32'd1);
    check("rst5_sdi1", 32'(SPI_SDI), 32'd1);
    check("rst5_busy", 32'(busy),    32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst5_no_done", 32'(done_total), 32'(dt_before));
    check("rst5_rdata",   32'(rdata),      32'h00);
    run_frame(1'b1, 6'h32, 8'h00, 0, done_n, csn_lo, busy_lo_n, rd, done_cnt, csn1, busy1);
    check("rst5_rd_rdata", 32'(rd),       32'h7F);
    check("rst5_rd_addr",  32'(m_addr),   32'hB2);
    check("rst5_rd_done",  32'(done_cnt), 32'd1);

    // start held high for three back-to-back writes
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 6'h15; wdata = 8'hC3;
    n_done = 0; n_gaps = 0; hi_run = 0; seen_low = 1'b0;
    for (int n = 1; n <= 260; n++) begin
      @(negedge clk);
      if (n == 141) start = 1'b0;
      if (done) begin
        if (n_done < 3) d_at[n_done] = n;
        n_done++;
      end
      if (SPI_CSN) begin
        if (seen_low) hi_run++;
      end else begin
        if (hi_run > 0 && n_gaps < 4) begin gaps[n_gaps] = hi_run; n_gaps++; end
        hi_run = 0;
        seen_low = 1'b1;
      end
    end
    check("b2b_done_cnt", 32'(n_done), 32'd3);
    check("b2b_n_gaps",   32'(n_gaps), 32'd2);
    if (n_done == 3) begin
      check("b2b_done0",  32'(d_at[0]),           32'd69);
      check("b2b_spc01",  32'(d_at[1] - d_at[0]), 32'd70);
      check("b2b_spc12",  32'(d_at[2] - d_at[1]), 32'd70);
    end
    if (n_gaps == 2) begin
      check("b2b_gap0", 32'(gaps[0]), 32'd2);
      check("b2b_gap1", 32'(gaps[1]), 32'd2);
    end
    check("b2b_m_data", 32'(m_data), 32'hC3);
    check("b2b_busy",   32'(busy),   32'd0);

    // Read once the data file is exhausted
    run_frame(1'b1, 6'h05, 8'h00, 0, done_n, csn_lo, busy_lo_n, rd, done_cnt, csn1, busy1);
    check("ex_rdata",    32'(rd),        32'h00);
    check("ex_done_cnt", 32'(done_cnt),  32'd1);
    check("ex_done_at",  32'(done_n),    32'd69);
    check("ex_busy_lo",  32'(busy_lo_n), 32'd71);
    check("ex_m_addr",   32'(m_addr),    32'h85);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_primary.md
SPI_PRIMARY -- requirements
Module: spi_primary

Interface
- REQ-001 SHALL have parameter CLK_DIV, default 25; SPI half-period in clk cycles (50 MHz clk -> 1 MHz SCLK); legal range 1..255.
- REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
- REQ-003 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
- REQ-004 SHALL have port start  input  1  transaction request; sampled only in IDLE.
- REQ-005 SHALL have port rw  input  1  1 = read, 0 = write; captured with start.
- REQ-006 SHALL have port addr  input  6  register address; captured with start.
- REQ-007 SHALL have port wdata  input  8  write data; captured with start.
- REQ-008 SHALL have port rdata  output  8  last read byte; held until the next read completes.
- REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until return to IDLE.
- REQ-010 SHALL have port done  output  1  one-cycle pulse at the end of each frame.
- REQ-011 SHALL have port SPI_CSN  output  1  chip select, active-low, idle high.
- REQ-012 SHALL have port SPI_CLK  output  1  SCLK, idle high (mode 3: CPOL=1, CPHA=1).
- REQ-013 SHALL have port SPI_SDI  output  1  data to secondary, idle high.
- REQ-014 SHALL have port SPI_SDO  input  1  data from secondary.

Function
- REQ-015 All outputs SHALL be registered.
- REQ-016 Frame SHALL be 16 bits, MSB first: {rw, 1'b0 (no multibyte), addr[5:0]}, then wdata[7:0] for writes or 8 don't-care bits (driven 1) for reads.
- REQ-017 FSM states SHALL be IDLE, SETUP, XFER, HOLD, GAP.
- REQ-018 IDLE: start=1 at edge k SHALL latch rw/addr/wdata, enter SETUP, and drive SPI_CSN=0 and busy=1 from k+1.
- REQ-019 SETUP SHALL last CLK_DIV cycles with SPI_CLK high, then enter XFER.
- REQ-020 XFER: per bit, SPI_CLK SHALL fall and SPI_SDI update in the same cycle, then rise CLK_DIV cycles later; the next bit falls CLK_DIV cycles after that.
- REQ-021 For bits 8..15 of a read, SPI_SDO SHALL be sampled in the cycle SPI_CLK rises, and shifted MSB first into a capture register.
- REQ-022 HOLD SHALL follow the 16th rising edge, last CLK_DIV cycles with SPI_CSN low and SPI_CLK high, then enter GAP.
- REQ-023 On entry to GAP, SPI_CSN SHALL go high and done SHALL pulse one cycle; for a read, rdata SHALL take the capture register in that same cycle.
- REQ-024 GAP SHALL last CLK_DIV cycles with busy=1, then return to IDLE with busy=0.
- REQ-025 Timing with start accepted at k: SPI_CSN low k+1..k+34*CLK_DIV; done at k+1+34*CLK_DIV; busy low at k+1+35*CLK_DIV.
- REQ-026 start while busy=1 SHALL be ignored and not queued.
- REQ-027 A write SHALL leave rdata unchanged.
- REQ-028 start held high continuously SHALL give back-to-back frames separated by exactly CLK_DIV cycles of SPI_CSN high.

Reset
- REQ-029 While reset_n=0, regardless of clk: state=IDLE, SPI_CSN=1, SPI_CLK=1, SPI_SDI=1, busy=0, done=0, rdata=0, counters=0.
- REQ-030 Reset mid-frame SHALL abort with no done pulse; the first start after release SHALL produce a complete, correct frame.

Structure
- REQ-031 Package spi_pkg SHALL hold the state encoding, FRAME_BITS=16, and the CLK_DIV default.
- REQ-032 Sub-module spi_tick_gen SHALL provide the CLK_DIV half-period tick; it is cleared on leaving IDLE, so every frame starts phase-aligned.

Verification (bench pairs the design with the existing SPI secondary mimic, CLK_DIV=2)
- REQ-033 Write addr=0x2D, wdata=0x08 -> mimic prints address 00101101 and data 00001000; SPI_CSN low exactly 68 cycles; done at k+69; rdata unchanged.
- REQ-034 Read addr=0x00, data file line 0xE5 -> mimic prints address 10000000; rdata=0xE5 in the done cycle.
- REQ-035 Second start pulse 10 cycles into a frame -> only one frame and one done pulse.
- REQ-036 reset_n low during bit 5 -> SPI_CSN, SPI_CLK and SPI_SDI high, busy=0 asynchronously; a following read of 0x32 (file line 0x7F) returns 0x7F.
- REQ-037 start held high for three frames -> SPI_CSN high gaps of exactly 2 cycles; three done pulses, each 70 cycles apart.
- REQ-038 Read after the data file is exhausted -> rdata=0x00, done still pulses.
